// File: rtl/config_rx.sv
// Receiver for the CONFIG_TX serial link: oversamples CFG_CLK/CFG_DAT/CFG_OE,
// shifts in one word MSB first and strobes it out when the bit count is exact.
`timescale 1ns/1ps
module config_rx #(
   parameter int C_NO_CFG_BITS    = 24,
   parameter int G_TIMEOUT_CYCLES = 256
) (
   input  logic                     CLOCK,
   input  logic                     RESET,
   input  logic                     CFG_CLK,
   input  logic                     CFG_DAT,
   input  logic                     CFG_OE,
   output logic [C_NO_CFG_BITS-1:0] CFG_DATA,
   output logic                     CFG_VALID,
   output logic                     CFG_ERROR,
   output logic                     BUSY,
   output logic [1:0]               DBG_STATE
);

   localparam int CW = $clog2(C_NO_CFG_BITS + 2);
   localparam int TW = $clog2(G_TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LP_N     = CW'(C_NO_CFG_BITS);
   localparam logic [CW-1:0] LP_N_SAT = CW'(C_NO_CFG_BITS + 1);
   localparam logic [TW-1:0] LP_T_END = TW'(G_TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RECV     = 2'd1,
      S_ERR_WAIT = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;

   // Bit order in the synchronizer vectors: [2]=oe, [1]=dat, [0]=clk.
   logic [2:0] r_sync1, r_sync2, r_dly;
   logic [1:0] r_fill;
   logic       r_armed;

   logic [C_NO_CFG_BITS-1:0] r_shift, w_shift_nxt;
   logic [CW-1:0]            r_cnt, w_cnt_nxt;
   logic [TW-1:0]            r_to;

   logic w_s_oe, w_s_dat, w_clk_rise, w_oe_rise, w_oe_fall, w_oe_start;
   logic w_to_term, w_load, w_err;

   assign w_s_oe     = r_sync2[2];
   assign w_s_dat    = r_sync2[1];
   assign w_clk_rise = r_sync2[0] & ~r_dly[0];
   assign w_oe_rise  = r_sync2[2] & ~r_dly[2];
   assign w_oe_fall  = ~r_sync2[2] & r_dly[2];
   assign w_oe_start = w_oe_rise & r_armed;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_dly   <= '0;
         r_fill  <= '0;
         r_armed <= 1'b0;
      end else begin
         r_sync1 <= {CFG_OE, CFG_DAT, CFG_CLK};
         r_sync2 <= r_sync1;
         r_dly   <= r_sync2;
         r_fill  <= {r_fill[0], 1'b1};
         // After reset, a transfer may only start once CFG_OE has really been seen low,
         // so a transfer interrupted by reset is dropped rather than half-received.
         if (r_fill[1] && !w_s_oe)
            r_armed <= 1'b1;
      end
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // A clock rise coinciding with the OE fall is counted before the length check.
   assign w_shift_nxt = w_clk_rise ? {r_shift[C_NO_CFG_BITS-2:0], w_s_dat} : r_shift;
   assign w_cnt_nxt   = (w_clk_rise && (r_cnt != LP_N_SAT)) ? r_cnt + CW'(1) : r_cnt;
   assign w_to_term   = w_s_oe && !w_clk_rise && (r_to == LP_T_END);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_oe_start) w_state_nxt = S_RECV;
         S_RECV: begin
            if (w_oe_fall)      w_state_nxt = S_IDLE;
            else if (w_to_term) w_state_nxt = S_ERR_WAIT;
         end
         S_ERR_WAIT: if (!w_s_oe) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_load = 1'b0;
      w_err  = 1'b0;
      if (r_state == S_RECV) begin
         w_load = w_oe_fall && (w_cnt_nxt == LP_N);
         w_err  = (w_oe_fall && (w_cnt_nxt != LP_N)) || w_to_term;
      end
   end

   assign BUSY      = (r_state != S_IDLE);
   assign DBG_STATE = r_state;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_to    <= '0;
      end else if (r_state != S_RECV) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_to    <= '0;
      end else begin
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_clk_rise)
            r_to <= '0;
         else if (r_to != LP_T_END)
            r_to <= r_to + TW'(1);
      end
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         CFG_DATA  <= '0;
         CFG_VALID <= 1'b0;
         CFG_ERROR <= 1'b0;
      end else begin
         CFG_VALID <= w_load;
         CFG_ERROR <= w_err;
         if (w_load)
            CFG_DATA <= w_shift_nxt;
      end
   end

endmodule

// File: tb/tb_config_rx.sv
// Bench for config_rx: directed serial transfers, scoreboard of expected strobes
// checked by an independent monitor.
`timescale 1ns/1ps
module tb_config_rx;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        CFG_CLK, CFG_DAT, CFG_OE;
   logic [23:0] CFG_DATA;
   logic        CFG_VALID, CFG_ERROR, BUSY;
   logic [1:0]  DBG_STATE;

   // Entry layout: {is_error, expected CFG_DATA}
   logic [24:0] exp_q[$];
   logic [23:0] model_data;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_err_cyc = -1;

   config_rx #(.C_NO_CFG_BITS(24), .G_TIMEOUT_CYCLES(256)) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .CFG_CLK   (CFG_CLK),
      .CFG_DAT   (CFG_DAT),
      .CFG_OE    (CFG_OE),
      .CFG_DATA  (CFG_DATA),
      .CFG_VALID (CFG_VALID),
      .CFG_ERROR (CFG_ERROR),
      .BUSY      (BUSY),
      .DBG_STATE (DBG_STATE)
   );

   // Clock / reset
   always #10 CLOCK = ~CLOCK;
   always @(posedge CLOCK) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_valid(input logic [23:0] word);
      exp_q.push_back({1'b0, word});
      model_data = word;
   endtask

   task automatic expect_error();
      exp_q.push_back({1'b1, model_data});
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   task automatic check_reset_values();
      chk("rst_data",  {8'd0, CFG_DATA}, 32'd0);
      chk("rst_valid", {31'd0, CFG_VALID}, 32'd0);
      chk("rst_error", {31'd0, CFG_ERROR}, 32'd0);
      chk("rst_busy",  {31'd0, BUSY}, 32'd0);
      chk("rst_state", {30'd0, DBG_STATE}, 32'd0);
   endtask

   // One transfer of nbits (MSB first). rst_after>0 pulses RESET after that many bits;
   // coincide drops CFG_OE on the same edge as the last CFG_CLK rise.
   task automatic xfer(input logic [31:0] word, input int nbits, input int rst_after,
                       input logic coincide);
      CFG_OE = 1'b1;
      wait_cyc(6);
      chk("busy_open", {31'd0, BUSY}, 32'd1);
      for (int i = nbits - 1; i >= 0; i--) begin
         CFG_DAT = word[i];
         wait_cyc(9);
         CFG_CLK = 1'b1;
         if (i == 0 && coincide) CFG_OE = 1'b0;
         wait_cyc(10);
         CFG_CLK = 1'b0;
         if (rst_after > 0 && (nbits - i) == rst_after) begin
            RESET = 1'b1;
            wait_cyc(3);
            check_reset_values();
            model_data = 24'd0;
            RESET = 1'b0;
            wait_cyc(2);
         end
      end
      if (!coincide) begin
         wait_cyc(5);
         CFG_OE = 1'b0;
      end
      wait_cyc(8);
      chk("busy_idle", {31'd0, BUSY}, 32'd0);
   endtask

   // Monitor / scoreboard
   always @(negedge CLOCK) begin
      if (!RESET && (CFG_VALID || CFG_ERROR)) begin
         logic [24:0] e;
         chk("strobe_exclusive", {31'd0, CFG_VALID & CFG_ERROR}, 32'd0);
         if (CFG_ERROR) last_err_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: valid=%0b error=%0b data=0x%0h, expected none",
                     CFG_VALID, CFG_ERROR, CFG_DATA);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_kind_data", {7'd0, CFG_ERROR, CFG_DATA}, {7'd0, e});
            if (CFG_VALID) chk("busy_low_at_valid", {31'd0, BUSY}, 32'd0);
         end
      end
   end

   // Stimulus
   initial begin
      int c0;
      RESET = 1'b1;
      CFG_CLK = 1'b0;
      CFG_DAT = 1'b0;
      CFG_OE  = 1'b0;
      model_data = 24'd0;
      wait_cyc(4);
      check_reset_values();
      RESET = 1'b0;
      wait_cyc(4);

      // Nominal
      expect_valid(24'hAEC9EC);
      xfer(32'h00AEC9EC, 24, 0, 1'b0);
      chk("nominal_data", {8'd0, CFG_DATA}, 32'h00AEC9EC);

      // Short and long
      expect_error();
      xfer(32'h00AEC9EC, 23, 0, 1'b0);
      expect_error();
      xfer(32'h01AEC9EC, 25, 0, 1'b0);
      chk("data_held_after_errors", {8'd0, CFG_DATA}, 32'h00AEC9EC);

      // Timeout: 10 clocks, 300-cycle stall, 14 more clocks
      expect_error();
      last_err_cyc = -1;
      CFG_OE = 1'b1;
      wait_cyc(6);
      c0 = 0;
      for (int i = 0; i < 10; i++) begin
         CFG_DAT = 1'($urandom_range(0, 1));
         wait_cyc(9);
         CFG_CLK = 1'b1;
         if (i == 9) c0 = cyc;
         wait_cyc(10);
         CFG_CLK = 1'b0;
      end
      wait_cyc(300);
      $display("timeout latency: %0d cycles after last CFG_CLK rise at pin", last_err_cyc - c0);
      chk("timeout_latency_window",
          {31'd0, (last_err_cyc - c0 >= 254) && (last_err_cyc - c0 <= 262)}, 32'd1);
      chk("err_wait_busy",  {31'd0, BUSY}, 32'd1);
      chk("err_wait_state", {30'd0, DBG_STATE}, 32'd2);
      for (int i = 0; i < 14; i++) begin
         CFG_DAT = 1'($urandom_range(0, 1));
         wait_cyc(9);
         CFG_CLK = 1'b1;
         wait_cyc(10);
         CFG_CLK = 1'b0;
      end
      wait_cyc(5);
      CFG_OE = 1'b0;
      wait_cyc(8);
      chk("timeout_back_idle", {30'd0, DBG_STATE}, 32'd0);
      chk("timeout_data_held", {8'd0, CFG_DATA}, 32'h00AEC9EC);

      // Reset mid-transfer, then a clean transfer
      xfer(32'h00FFFFFF, 24, 12, 1'b0);
      chk("dropped_data_zero", {8'd0, CFG_DATA}, 32'd0);
      expect_valid(24'h123456);
      xfer(32'h00123456, 24, 0, 1'b0);

      // Last CFG_CLK rise coincides with CFG_OE fall
      expect_valid(24'h5A5A5B);
      xfer(32'h005A5A5B, 24, 0, 1'b1);

      // Loopback-style back-to-back transfers
      for (int k = 0; k < 3; k++) begin
         expect_valid(24'hAEC9EC);
         xfer(32'h00AEC9EC, 24, 0, 1'b0);
      end

      wait_cyc(10);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
